temp_comparator: RTL and testbench
==================================

# temp_comparator

Front-end block that generates the `temp_comp` code consumed by `AC_Controller`. It averages a stream of raw temperature samples over a 4-sample window and compares the average against a setpoint with hysteresis. It then debounces the decision, so the controller only sees a changed `temp_comp` after the condition has held for `STABLE` consecutive evaluations.

## Interface
- `WIDTH`, 8: bit width of the temperature sample and of the setpoint (unsigned).
- `HYST`, 1: hysteresis band in LSBs; legal range 0..(2^WIDTH−1).
- `STABLE`, 3: consecutive agreeing evaluations required to change `temp_comp`; legal range 1..15.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `sample_valid`  in  1: `sample_temp` is valid this cycle. The block is always ready, and back-to-back valid cycles are legal.
- `sample_temp`  in  WIDTH: raw sensor reading (unsigned).
- `setpoint`  in  WIDTH: target temperature (unsigned). Sampled live at each evaluation.
- `temp_comp`  out  2: registered code. 2'b00 means equal, 2'b10 means average higher than setpoint (cool), 2'b01 means average lower (heat). 2'b11 is never driven.
- `comp_changed`  out  1: one-cycle pulse in the cycle that `temp_comp` takes a new value.

## Operation
- **Window**
  - 4-entry shift register of accepted samples, with a running sum of WIDTH+2 bits and a fill counter that saturates at 4.
  - Each `sample_valid` shifts in `sample_temp`, drops the oldest entry and updates the sum.
- **Average:** `avg = sum >> 2` (floor).
- **Evaluation**
  - Occurs in the cycle after each accepted sample, and only once the fill counter is 4.
  - While the window is not full, no evaluation happens and `temp_comp` holds its value.
- **Comparisons:** all are done at WIDTH+1 bits (zero-extended) so that `setpoint+HYST` and `avg+HYST` never wrap.
- **State machine:** states EQUAL (00), HIGH (10), LOW (01); reset state EQUAL. The raw decision depends on the current state:
  - In EQUAL:
    - HIGH if `avg > setpoint+HYST`.
    - LOW if `avg+HYST < setpoint`.
    - Otherwise EQUAL.
  - In HIGH:
    - LOW if `avg+HYST < setpoint`.
    - Else EQUAL if `avg <= setpoint`.
    - Otherwise HIGH.
  - In LOW:
    - HIGH if `avg > setpoint+HYST`.
    - Else EQUAL if `avg >= setpoint`.
    - Otherwise LOW.
- **Debounce:** uses a `candidate` register and a `count` register of 4 bits.
  - If raw equals the current state: `count` is cleared to 0.
  - Else if raw equals `candidate`: `count` is incremented.
  - Else: `candidate` takes raw and `count` is set to 1.
  - When the updated `count` reaches `STABLE`: the state takes `candidate`, `count` is cleared to 0, and `comp_changed` pulses.
  - When `STABLE` is 1, a single disagreeing evaluation changes the state.
- **No evaluation:** in a cycle with no evaluation, `count`, `candidate` and the state are unchanged; a gap in `sample_valid` does not clear the debounce.
- **Setpoint changes:** take effect at the next evaluation. They do not refill or clear the window.

## Timing
- **Reset values:** `temp_comp` = 2'b00 and `comp_changed` = 0. The window, sum, fill counter, `count` and `candidate` (EQUAL) are all cleared. Outputs go to these values immediately on `reset` assertion, without waiting for a clock edge.
- **First evaluation:** `sample_valid` at edge k loads the window; the evaluation using that window happens at edge k+1. The first evaluation follows the 4th accepted sample after reset.
- **Latency to a state change:** `temp_comp` and `comp_changed` update at edge k+1 after the sample whose evaluation completes the `STABLE`-th agreement.
- **Pulse width:** `comp_changed` is high for exactly one cycle per change.
- **Reset during operation:** reset asserted mid-operation discards the window. Four new samples are needed before the next evaluation.
- **Outputs are registered:** there is no combinational path from any input to `temp_comp` or `comp_changed`.

## Test plan
All scenarios use WIDTH=8, HYST=1, STABLE=3 and setpoint 22 unless stated otherwise.

1. **Window not full:** reset, then 3 samples of 40 → `temp_comp` stays 00 and `comp_changed` stays 0.
2. **Transition to HIGH:** reset, then 6 back-to-back samples of 25 (avg 25 > 23) → `temp_comp` becomes 10 one cycle after the 6th sample, with a single-cycle `comp_changed` pulse. It is 00 before that cycle.
3. **Hysteresis release:** from HIGH, 4+ samples of 23 → `temp_comp` stays 10. Then 6 samples of 22 → 00 after the third evaluation with avg 22, with one pulse.
4. **Glitch rejection:** window full of 22, state EQUAL. Set setpoint to 20 for 2 samples (raw HIGH), then back to 22 for 5 samples → `temp_comp` remains 00 and no pulse occurs.
5. **Heat and no wraparound:**
   - setpoint 255 with samples 0 → LOW (01) after the 6th sample.
   - setpoint 255 with samples 255, and setpoint 0 with samples 0 → EQUAL, with no wraparound at the range extremes.
6. **Asynchronous reset mid-operation:** in HIGH, assert reset between clock edges → `temp_comp` is 00 immediately. After release, 3 samples of 25 leave it at 00. The 6th sample after release gives 10.

Source files
------------

// File: rtl/temp_comparator.sv
// Averages the last four accepted temperature samples, compares the average with
// the setpoint using hysteresis, and debounces the result into a registered code.
module temp_comparator #(
  parameter int WIDTH  = 8,
  parameter int HYST   = 1,
  parameter int STABLE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_temp,
  input  logic [WIDTH-1:0] setpoint,
  output logic [1:0]       temp_comp,
  output logic             comp_changed
);

  typedef enum logic [1:0] {
    ST_EQUAL = 2'b00,
    ST_LOW   = 2'b01,
    ST_HIGH  = 2'b10
  } state_e;

  localparam logic [WIDTH:0] HYST_E   = (WIDTH+1)'(HYST);
  localparam logic [3:0]     STABLE_C = 4'(STABLE);

  // Sample window: win_q[0] is the newest entry, win_q[3] the oldest.
  logic [WIDTH-1:0] win_q [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_win
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge reset) begin
          if (reset)             win_q[gi] <= '0;
          else if (sample_valid) win_q[gi] <= sample_temp;
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge reset) begin
          if (reset)             win_q[gi] <= '0;
          else if (sample_valid) win_q[gi] <= win_q[gi-1];
        end
      end
    end
  endgenerate

  logic [WIDTH+1:0] sum_q, sum_d;
  logic [2:0]       fill_q, fill_d;
  logic             eval_q, eval_d;

  always_comb begin
    sum_d  = sum_q;
    fill_d = fill_q;
    if (sample_valid) begin
      sum_d = sum_q + {2'b00, sample_temp} - {2'b00, win_q[3]};
      if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
    end
    eval_d = sample_valid && (fill_d == 3'd4);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q  <= '0;
      fill_q <= '0;
      eval_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      fill_q <= fill_d;
      eval_q <= eval_d;
    end
  end

  // Comparisons are one bit wider so setpoint+HYST and avg+HYST cannot wrap.
  logic [WIDTH-1:0] avg;
  logic [WIDTH:0]   avg_e, sp_e;
  logic             above, below;

  assign avg   = WIDTH'(sum_q >> 2);
  assign avg_e = {1'b0, avg};
  assign sp_e  = {1'b0, setpoint};
  assign above = avg_e > (sp_e + HYST_E);
  assign below = (avg_e + HYST_E) < sp_e;

  state_e     state_q, state_d;
  state_e     cand_q, cand_d;
  state_e     raw;
  logic [3:0] cnt_q, cnt_d, cnt_n;
  logic       changed_q, changed_d;

  always_comb begin
    raw = ST_EQUAL;
    case (state_q)
      ST_EQUAL: begin
        if (above)      raw = ST_HIGH;
        else if (below) raw = ST_LOW;
        else            raw = ST_EQUAL;
      end
      ST_HIGH: begin
        if (below)              raw = ST_LOW;
        else if (avg_e <= sp_e) raw = ST_EQUAL;
        else                    raw = ST_HIGH;
      end
      ST_LOW: begin
        if (above)              raw = ST_HIGH;
        else if (avg_e >= sp_e) raw = ST_EQUAL;
        else                    raw = ST_LOW;
      end
      default: raw = ST_EQUAL;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    cnt_n     = cnt_q;
    changed_d = 1'b0;
    if (eval_q) begin
      if (raw == state_q) begin
        cnt_n = 4'd0;
      end else if (raw == cand_q) begin
        cnt_n = cnt_q + 4'd1;
      end else begin
        cand_d = raw;
        cnt_n  = 4'd1;
      end
      cnt_d = cnt_n;
      if (cnt_n == STABLE_C) begin
        state_d   = cand_d;
        cnt_d     = 4'd0;
        changed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_EQUAL;
      cand_q    <= ST_EQUAL;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  assign temp_comp    = state_q;
  assign comp_changed = changed_q;

endmodule

// File: tb/tb_temp_comparator.sv
// Bench for temp_comparator: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a queue-based reference model.
module tb_temp_comparator;

  localparam int WIDTH  = 8;
  localparam int HYST   = 1;
  localparam int STABLE = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sample_valid = 1'b0;
  logic [WIDTH-1:0] sample_temp = '0;
  logic [WIDTH-1:0] setpoint = 8'd22;
  logic [1:0]       temp_comp;
  logic             comp_changed;

  int n_checks = 0;
  int n_fail   = 0;

  temp_comparator #(.WIDTH(WIDTH), .HYST(HYST), .STABLE(STABLE)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_temp  (sample_temp),
    .setpoint     (setpoint),
    .temp_comp    (temp_comp),
    .comp_changed (comp_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: codes are 0 = equal, 2 = high (cool), 1 = low (heat).
  int q[$];
  bit pend = 0;
  int pavg = 0;
  int m_state = 0, m_cand = 0, m_cnt = 0;
  bit m_chg = 0;

  function automatic int decide(input int cur, input int a, input int sp);
    bit hi = a > sp + HYST;
    bit lo = a + HYST < sp;
    if (cur == 0) return hi ? 2 : (lo ? 1 : 0);
    if (cur == 2) return lo ? 1 : ((a <= sp) ? 0 : 2);
    return hi ? 2 : ((a >= sp) ? 0 : 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      pend = 0; m_state = 0; m_cand = 0; m_cnt = 0; m_chg = 0;
    end else begin
      int raw;
      m_chg = 0;
      if (pend) begin
        raw = decide(m_state, pavg, int'(setpoint));
        if (raw == m_state) m_cnt = 0;
        else if (raw == m_cand) m_cnt++;
        else begin m_cand = raw; m_cnt = 1; end
        if (m_cnt == STABLE) begin
          m_state = m_cand; m_cnt = 0; m_chg = 1;
        end
      end
      pend = 0;
      if (sample_valid) begin
        q.push_back(int'(sample_temp));
        if (q.size() > 4) void'(q.pop_front());
        if (q.size() == 4) begin
          pend = 1;
          pavg = (q[0] + q[1] + q[2] + q[3]) / 4;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_temp_comp", int'(temp_comp), m_state);
    check("model_comp_changed", int'(comp_changed), int'(m_chg));
  end

  task automatic send(input int n, input int v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_temp  = WIDTH'(v);
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Reset asserted between clock edges; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_temp_comp", int'(temp_comp), 0);
    check("async_reset_comp_changed", int'(comp_changed), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Window never fills.
    setpoint = 8'd22;
    send(3, 40);
    repeat (2) @(negedge clk);
    check("not_full_temp_comp", int'(temp_comp), 0);

    // Transition to HIGH one cycle after the sixth sample.
    do_reset();
    send(6, 25);
    check("high_before", int'(temp_comp), 0);
    @(negedge clk);
    check("high_after", int'(temp_comp), 2);
    check("high_pulse", int'(comp_changed), 1);
    @(negedge clk);
    check("high_pulse_end", int'(comp_changed), 0);

    // Hysteresis hold at 23, release at 22 after the third evaluation.
    send(5, 23);
    check("hyst_hold", int'(temp_comp), 2);
    send(3, 22);
    check("release_before", int'(temp_comp), 2);
    @(negedge clk);
    check("release_after", int'(temp_comp), 0);
    check("release_pulse", int'(comp_changed), 1);
    send(3, 22);

    // Short setpoint glitch must not change the output.
    setpoint = 8'd20;
    send(2, 22);
    setpoint = 8'd22;
    send(5, 22);
    check("glitch_reject", int'(temp_comp), 0);

    // Heat at the bottom of the range, then equal at the top without wrap.
    do_reset();
    setpoint = 8'd255;
    send(6, 0);
    check("low_before", int'(temp_comp), 0);
    @(negedge clk);
    check("low_after", int'(temp_comp), 1);
    send(6, 255);
    @(negedge clk);
    check("top_equal", int'(temp_comp), 0);
    send(4, 255);
    check("top_no_wrap", int'(temp_comp), 0);
    do_reset();
    setpoint = 8'd0;
    send(8, 0);
    check("bottom_no_wrap", int'(temp_comp), 0);

    // Reset in HIGH discards the window.
    setpoint = 8'd22;
    do_reset();
    send(6, 25);
    @(negedge clk);
    check("pre_reset_high", int'(temp_comp), 2);
    do_reset();
    send(3, 25);
    repeat (2) @(negedge clk);
    check("post_reset_partial", int'(temp_comp), 0);
    send(3, 25);
    @(negedge clk);
    check("post_reset_high", int'(temp_comp), 2);

    // Randomized traffic near the setpoint with occasional extremes and resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 799) == 0) begin
        sample_valid = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      sample_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) sample_temp = WIDTH'($urandom_range(0, 255));
      else                            sample_temp = WIDTH'($urandom_range(17, 27));
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 5))
          0:       setpoint = 8'd0;
          1:       setpoint = 8'd255;
          default: setpoint = WIDTH'($urandom_range(19, 25));
        endcase
      end
    end
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
